uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter. It is the next generation of the team's fixed 8N1 transmitter, with these additions:
- configurable data width;
- optional even/odd parity;
- one or two stop bits;
- an internal programmable baud divider, so no external baud strobe is needed.

It sits between the register/command front-end and the TX pin. It uses the same trmt/tx_done handshake as the existing transmitter, so it is a drop-in replacement.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_cfg.sv | 155 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter and,
// later, the matching receiver.
//   parity_t      : decoded parity selection
//   tx_state_t    : transmitter frame states
//   MIN_BAUD_DIV  : smallest usable clocks-per-bit value
//   decode_parity : maps the raw 2-bit parity_mode input onto parity_t
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MIN_BAUD_DIV = 2;

    // Code 2'b11 has no meaning of its own and is treated as "no parity".
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator. Counts 0..div-1 while enabled and pulses tick for
// one clock at div-1, which marks the bit boundary. Dropping en clears the
// count, so the next enable starts a full bit period.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the divider; low holds the count at zero
//   div        : clocks per bit, expected to be already clamped to >= 2
//   tick       : one-cycle pulse on the last clock of each bit period
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == (div - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with the trmt/tx_done handshake.
// Frame: start, DATA_BITS data (LSB first), optional parity, 1 or 2 stops.
// All frame settings are captured when trmt is accepted in IDLE.
//   clk, rst_n  : clock, asynchronous active-low reset
//   trmt        : start-frame strobe, only looked at in IDLE
//   tx_data     : payload
//   baud_div    : clocks per bit (0 and 1 behave as 2)
//   parity_mode : 00/11 none, 01 even, 10 odd
//   two_stop    : 1 = two stop bits
//   TX          : serial line, idles high
//   tx_done     : idle and the previous frame complete
//   busy        : frame in progress
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | line marking, waiting for trmt
// START  | start bit on the line
// DATA   | data bits, bit_cnt counts them
// PARITY | parity bit on the line
// STOP   | stop bit(s), bit_cnt selects first/second
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 TX,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int SH_W  = DATA_BITS + 2;
    localparam int CNT_W = 4;

    tx_state_t        state_q,    state_d;
    logic [SH_W-1:0]  shreg_q,    shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [DIV_W-1:0] div_q,      div_d;
    parity_t          par_mode_q, par_mode_d;
    logic             two_stop_q, two_stop_d;

    logic             tick;
    logic [DIV_W-1:0] eff_div;
    logic             par_bit;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q != IDLE),
        .div  (div_q),
        .tick (tick)
    );

    assign eff_div = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;

    // Without parity the top shift-register bit is a 1, so it doubles as
    // the first stop bit.
    always_comb begin
        case (decode_parity(parity_mode))
            PAR_EVEN: par_bit = ^tx_data;
            PAR_ODD:  par_bit = ~^tx_data;
            default:  par_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;

        // tick only fires outside IDLE; 1-fill supplies the stop bits.
        if (tick) begin
            shreg_d = {1'b1, shreg_q[SH_W-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (trmt) begin
                    state_d    = START;
                    shreg_d    = {par_bit, tx_data, 1'b0};
                    bit_cnt_d  = '0;
                    div_d      = eff_div;
                    par_mode_d = decode_parity(parity_mode);
                    two_stop_d = two_stop;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (par_mode_q != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (two_stop_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '1;
            bit_cnt_q  <= '0;
            div_q      <= DIV_W'(MIN_BAUD_DIV);
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
        end
    end

    assign TX      = shreg_q[0];
    assign tx_done = (state_q == IDLE);
    assign busy    = ~tx_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg (DATA_BITS=8). Stimulus pushes the
// expected frame (bit levels, bit period, expected idle gap) into a queue;
// the monitor pops an entry whenever busy rises and checks the line clock
// by clock, then the frame-end handshake.
module tb_uart_tx_cfg;

    localparam int DATA_BITS = 8;
    localparam int DIV_W     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 trmt = 1'b0;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic [DIV_W-1:0]     baud_div = 16'd4;
    logic [1:0]           parity_mode = 2'b00;
    logic                 two_stop = 1'b0;
    logic                 TX;
    logic                 tx_done;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          d;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_cfg #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .TX         (TX),
        .tx_done    (tx_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // par is the hand-computed parity bit; ignored when parity is off.
    function automatic exp_t make_exp(input logic [7:0] data, input logic [1:0] pm,
                                      input logic par, input logic ts, input int bd,
                                      input int gap);
        exp_t e;
        int   n;
        e.bits    = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = data[i];
        n = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            e.bits[n] = par;
            n++;
        end
        n += ts ? 2 : 1;
        e.nbits = n;
        e.d     = (bd < 2) ? 2 : bd;
        e.gap   = gap;
        return e;
    endfunction

    task automatic launch(input logic [7:0] data, input logic [1:0] pm, input logic par,
                          input logic ts, input int bd, input int gap);
        @(negedge clk);
        tx_data     = data;
        parity_mode = pm;
        two_stop    = ts;
        baud_div    = 16'(bd);
        trmt        = 1'b1;
        exp_q.push_back(make_exp(data, pm, par, ts, bd, gap));
        @(posedge clk);
        #1 trmt = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        checks++;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            done = (tx_done === 1'b1);
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: tx_done=%b after 4000 clocks, required 1", name, tx_done);
        end
    endtask

    initial begin : monitor
        int   idle_cnt;
        int   total;
        int   bad;
        bit   aborted;
        exp_t it;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                idle_cnt = 0;
            end else if (busy !== 1'b1) begin
                idle_cnt++;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: busy=%b with nothing pending, required 0", busy);
                for (int i = 0; i < 4000 && busy === 1'b1 && rst_n === 1'b1; i++) @(negedge clk);
                idle_cnt = 0;
            end else begin
                it    = exp_q.pop_front();
                total = it.nbits * it.d;
                if (it.gap >= 0) check("frame_gap", idle_cnt, it.gap);
                bad     = 0;
                aborted = 1'b0;
                for (int k = 0; k < total; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (TX !== it.bits[k / it.d] || busy !== 1'b1) bad++;
                end
                if (aborted) begin
                    idle_cnt = 0;
                end else begin
                    check("frame_bad_samples", bad, 0);
                    @(negedge clk);
                    check("frame_end_done_busy_tx", {29'd0, tx_done, busy, TX}, 32'b101);
                    idle_cnt = (tx_done === 1'b1) ? 1 : 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx_done_busy_tx", {29'd0, tx_done, busy, TX}, 32'b101);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {29'd0, tx_done, busy, TX}, 32'b101);

        // 0xA5, no parity, 1 stop, D=4: 10 bits, 40 clocks
        launch(8'hA5, 2'b00, 1'b0, 1'b0, 4, -1);
        wait_idle("a5_none");
        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        launch(8'h07, 2'b01, 1'b1, 1'b0, 4, -1);
        wait_idle("07_even");
        launch(8'h07, 2'b10, 1'b0, 1'b0, 4, -1);
        wait_idle("07_odd");
        // mode 11 is "no parity"
        launch(8'h81, 2'b11, 1'b0, 1'b0, 3, -1);
        wait_idle("81_mode11");
        // two stops, D=3: 9 low bits (27 clk) then 2 high (6 clk)
        launch(8'h00, 2'b00, 1'b0, 1'b1, 3, -1);
        wait_idle("00_two_stop");
        // baud_div 0 clamps to 2
        launch(8'h5A, 2'b00, 1'b0, 1'b0, 0, -1);
        wait_idle("5a_div0");

        // baud_div 1 clamps to 2; 0x3C has four ones -> even parity 0.
        // Inputs change mid-frame and a trmt pulse arrives; neither may matter.
        launch(8'h3C, 2'b01, 1'b0, 1'b0, 1, -1);
        repeat (6) @(negedge clk);
        tx_data     = 8'hC3;
        parity_mode = 2'b10;
        baud_div    = 16'd9;
        two_stop    = 1'b1;
        trmt        = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        wait_idle("3c_midchange");

        // trmt held: three frames of 20 clocks, accepted at N, N+21, N+42
        @(negedge clk);
        tx_data     = 8'h96;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        baud_div    = 16'd2;
        exp_q.push_back(make_exp(8'h96, 2'b00, 1'b0, 1'b0, 2, -1));
        exp_q.push_back(make_exp(8'h96, 2'b00, 1'b0, 1'b0, 2, 1));
        exp_q.push_back(make_exp(8'h96, 2'b00, 1'b0, 1'b0, 2, 1));
        trmt = 1'b1;
        @(posedge clk);
        repeat (42) @(posedge clk);
        #1 trmt = 1'b0;
        wait_idle("96_held");

        // reset in the middle of the data bits of an all-zero payload
        launch(8'h00, 2'b00, 1'b0, 1'b0, 4, -1);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, TX}, 32'd1);
        check("async_reset_done", {31'd0, tx_done}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_hold_tx", {31'd0, TX}, 32'd1);
        #2 rst_n = 1'b1;

        // 0xC4 has three ones -> even parity 1; two stops, D=5: 12 bits
        launch(8'hC4, 2'b01, 1'b1, 1'b1, 5, -1);
        wait_idle("c4_after_reset");

        repeat (40) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
